// File: rtl/fnd_pkg.sv
// Shared types and font table for the 4-digit FND scan display.
// Segment bytes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t FONT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam seg_t SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    DIG_ONES,
    DIG_TENS,
    DIG_HUND,
    DIG_THOU
  } digit_e;

endpackage

// File: rtl/fnd_bcd2seg.sv
// BCD digit plus blank flag to active-low segment pattern.
// Codes above 9 show blank.
module fnd_bcd2seg
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_bcd < 4'd10)) begin
      o_seg = FONT[i_bcd];
    end
  end

endmodule

// File: rtl/fnd_scan_display.sv
// 8-bit value to 4-digit multiplexed common-anode FND, frame-latched.
// Define FND_LZB_EN to blank leading zeros.
module fnd_scan_display
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font,
  output logic       scan_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("fnd_scan_display: CLK_HZ/SCAN_HZ must be >= 2");
    end
  endgenerate

  logic [CW-1:0] r_tick_cnt;
  digit_e        r_digit_sel;
  logic [7:0]    r_disp;
  logic          r_scan_tick;
  logic [3:0]    r_comm;
  seg_t          r_font;

  logic [3:0] w_ones;
  logic [3:0] w_tens;
  logic [3:0] w_hund;
  logic [3:0] w_bcd;
  logic       w_blank;
  seg_t       w_seg;

  assign w_ones = 4'(r_disp % 8'd10);
  assign w_tens = 4'((r_disp / 8'd10) % 8'd10);
  assign w_hund = 4'(r_disp / 8'd100);

  always_comb begin
    w_bcd   = 4'd0;
    w_blank = 1'b0;
    unique case (r_digit_sel)
      DIG_ONES: w_bcd = w_ones;
      DIG_TENS: begin
        w_bcd = w_tens;
`ifdef FND_LZB_EN
        w_blank = (w_hund == 4'd0) && (w_tens == 4'd0);
`endif
      end
      DIG_HUND: begin
        w_bcd = w_hund;
`ifdef FND_LZB_EN
        w_blank = (w_hund == 4'd0);
`endif
      end
      DIG_THOU: begin
        w_bcd = 4'd0;
`ifdef FND_LZB_EN
        w_blank = 1'b1;
`endif
      end
      default: w_bcd = 4'd0;
    endcase
  end

  fnd_bcd2seg u_bcd2seg (
    .i_bcd   (w_bcd),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Tick is registered, so it is armed one count early to line up with DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_scan_tick <= 1'b0;
      r_digit_sel <= DIG_ONES;
      r_disp      <= 8'd0;
      r_comm      <= 4'b1111;
      r_font      <= SEG_BLANK;
    end else begin
      if (r_tick_cnt == CW'(DIV - 1)) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_scan_tick <= (r_tick_cnt == CW'(DIV - 2));
      if (r_scan_tick) begin
        r_digit_sel <= digit_e'(r_digit_sel + 2'd1);
        if (r_digit_sel == DIG_THOU) begin
          r_disp <= data_in;
        end
      end
      r_comm <= ~(4'b0001 << r_digit_sel);
      r_font <= w_seg;
    end
  end

  assign fnd_comm  = r_comm;
  assign fnd_font  = r_font;
  assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_fnd_scan_display.sv
// Scoreboard bench for fnd_scan_display with DIV=4.
// Expected digit/font derived from cycle count and decimal arithmetic.
module tb_fnd_scan_display;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;
  logic       scan_tick;

  int checks = 0;
  int failures = 0;

  fnd_scan_display #(
    .CLK_HZ  (1000),
    .SCAN_HZ (250)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .fnd_comm  (fnd_comm),
    .fnd_font  (fnd_font),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] comm;
    logic [7:0] font;
    int         val;
    int         dig;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] font_tab [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] ref_font(int v, int d);
    int  dg [4];
    bit  blank;
    dg[0] = v % 10;
    dg[1] = (v / 10) % 10;
    dg[2] = v / 100;
    dg[3] = 0;
    blank = 1'b0;
`ifdef FND_LZB_EN
    blank = (d == 3) || (d == 2 && v < 100) || (d == 1 && v < 10);
`endif
    return blank ? 8'hFF : font_tab[dg[d]];
  endfunction

  // Model: m_c = clock edges since the last reset edge; m_cap = latched value.
  int m_c = 0;
  int m_cap = 0;

  always @(posedge clk) begin
    exp_t e;
    int   d;
    if (rst) begin
      m_c   = 0;
      m_cap = 0;
    end else begin
      m_c = m_c + 1;
      if (m_c % FRAME == 0) m_cap = int'(data_in);
      if (m_c % DIV == DIV - 1) begin
        d      = (m_c / DIV) % 4;
        e.comm = ~(4'b0001 << d);
        e.font = ref_font(m_cap, d);
        e.val  = m_cap;
        e.dig  = d;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: the scan_tick cycle is where a digit's outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (scan_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick t=%0t comm=%b font=%h", $time, fnd_comm, fnd_font);
      end else begin
        e = exp_q.pop_front();
        if (fnd_comm !== e.comm || fnd_font !== e.font) begin
          failures++;
          $display("FAIL digit%0d val=%0d got comm=%b font=%h exp comm=%b font=%h",
                   e.dig, e.val, fnd_comm, fnd_font, e.comm, e.font);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      failures++;
      e = exp_q.pop_front();
      $display("FAIL missed_tick t=%0t digit%0d got tick=%b exp tick=1", $time, e.dig, scan_tick);
    end
  end

  task automatic chk_reset(string nm);
    @(negedge clk);
    #2;
    checks++;
    if (fnd_comm !== 4'b1111 || fnd_font !== 8'hFF || scan_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s got comm=%b font=%h tick=%b exp comm=1111 font=ff tick=0",
               nm, fnd_comm, fnd_font, scan_tick);
    end
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_digit(int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if ((m_c / DIV) % 4 == d) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_digit%0d got timeout exp reached", d);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      chk_reset("reset_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    data_in = 8'd55;
    run(3 * FRAME);
    data_in = 8'd255;
    run(2 * FRAME);
    data_in = 8'd55;
    run(FRAME);
    wait_digit(1);
    data_in = 8'd7;
    run(2 * FRAME);
    data_in = 8'd0;
    run(2 * FRAME);
    data_in = 8'd100;
    run(2 * FRAME);

    for (int i = 0; i < 20; i++) begin
      data_in = 8'($urandom_range(0, 255));
      run(int'($urandom_range(1, 40)));
    end

    wait_digit(2);
    rst = 1'b1;
    @(posedge clk);
    chk_reset("reset_mid_scan");
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in = 8'd209;
    run(3 * FRAME);

    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL pending_expect got %0d exp <=1", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
